dmem_io_bridge: RTL and testbench



---
 rtl/dmem_io_pkg.sv | 15 +
 rtl/uart_tx_fsm.sv | 84 ++++++++
 rtl/dmem_io_bridge.sv | 132 +++++++++++++
 tb/tb_dmem_io_bridge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_pkg.sv
// Shared types and I/O register offsets for the data-memory / MMIO bridge.
package dmem_io_pkg;

  // Byte offsets within the I/O register block
  localparam logic [4:0] IO_LED   = 5'h00;
  localparam logic [4:0] IO_SW    = 5'h04;
  localparam logic [4:0] IO_TIMER = 5'h08;
  localparam logic [4:0] IO_UART  = 5'h0C;
  localparam logic [4:0] IO_SEG   = 5'h10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  typedef enum logic [1:0] {SEL_RAM, SEL_IO, SEL_NONE} sel_t;

endpackage

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_fsm
  import dmem_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          bit_last;

  assign bit_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx         = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        if (start) begin
          shift_n = data;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_last) begin
          baud_cnt_n = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_last) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_io_bridge.sv
// MEM-stage bridge: decodes core loads/stores to data RAM or MMIO registers,
// returning registered load data one cycle after MemRead.
module dmem_io_bridge
  import dmem_io_pkg::*;
#(
  parameter int unsigned DMEM_WORDS   = 1024,
  parameter logic [31:0] DMEM_BASE    = 32'h1001_0000,
  parameter logic [31:0] IO_BASE      = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_MS  = 100000,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] seg_value,
  output logic        uart_tx
);

  localparam int unsigned IDX_W     = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_SPAN = 32'(4 * DMEM_WORDS);
  localparam logic [31:0] PRE_LAST  = 32'(CLKS_PER_MS - 1);

  logic [31:0]      ram_off;
  logic             ram_hit, io_hit, io_wr;
  logic [IDX_W-1:0] ram_idx;
  logic [4:0]       io_off;

  // Addresses below the base wrap to huge offsets, so one unsigned compare covers both bounds
  assign ram_off = dAddress - DMEM_BASE;
  assign ram_hit = (ram_off < DMEM_SPAN);
  assign ram_idx = ram_off[IDX_W+1:2];
  assign io_hit  = (dAddress[31:5] == IO_BASE[31:5]);
  assign io_off  = {dAddress[4:2], 2'b00};
  assign io_wr   = MemWrite && io_hit;

  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] ram_q;

  // NOTE: RAM array and its read register have no reset, which keeps them mappable to block RAM.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) mem[ram_idx] <= dWriteData;
    if (MemRead && ram_hit)  ram_q <= mem[ram_idx];
  end

  logic [15:0] sw_meta, sw_sync;
  logic [31:0] timer_pre, timer_count;
  logic        uart_busy, uart_start;

  assign uart_start = io_wr && (io_off == IO_UART);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      led       <= '0;
      seg_value <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (io_wr && io_off == IO_LED) led       <= dWriteData[15:0];
      if (io_wr && io_off == IO_SEG) seg_value <= dWriteData;
    end
  end

  // A timer write outranks a tick landing on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_pre   <= '0;
      timer_count <= '0;
    end else if (io_wr && io_off == IO_TIMER) begin
      timer_pre   <= '0;
      timer_count <= '0;
    end else if (timer_pre == PRE_LAST) begin
      timer_pre   <= '0;
      timer_count <= timer_count + 1'b1;
    end else begin
      timer_pre <= timer_pre + 1'b1;
    end
  end

  uart_tx_fsm #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (uart_start),
    .data  (dWriteData[7:0]),
    .tx    (uart_tx),
    .busy  (uart_busy)
  );

  logic [31:0] io_rd_data, io_q;
  sel_t        sel_q;

  always_comb begin
    io_rd_data = '0;
    case (io_off)
      IO_LED:   io_rd_data = {16'b0, led};
      IO_SW:    io_rd_data = {16'b0, sw_sync};
      IO_TIMER: io_rd_data = timer_count;
      IO_UART:  io_rd_data = {31'b0, uart_busy};
      IO_SEG:   io_rd_data = seg_value;
      default:  io_rd_data = '0;
    endcase
  end

  // Read steering and I/O data only update on a load, so dReadData holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_NONE;
      io_q  <= '0;
    end else if (MemRead) begin
      io_q <= io_rd_data;
      if (ram_hit)     sel_q <= SEL_RAM;
      else if (io_hit) sel_q <= SEL_IO;
      else             sel_q <= SEL_NONE;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM: dReadData = ram_q;
      SEL_IO:  dReadData = io_q;
      default: dReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Scoreboard bench for dmem_io_bridge: loads push expected data, a monitor checks dReadData.
module tb_dmem_io_bridge;

  localparam int unsigned CPM = 10;
  localparam int unsigned CPB = 4;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_SW    = 32'hFFFF_0004;
  localparam logic [31:0] A_TIMER = 32'hFFFF_0008;
  localparam logic [31:0] A_UART  = 32'hFFFF_000C;
  localparam logic [31:0] A_SEG   = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dAddress = '0;
  logic [31:0] dWriteData = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dReadData;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic [31:0] seg_value;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  dmem_io_bridge #(
    .CLKS_PER_MS  (CPM),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dReadData  (dReadData),
    .sw         (sw),
    .led        (led),
    .seg_value  (seg_value),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Each bus operation occupies exactly one rising edge
  task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] data, input string name, input logic [31:0] exp);
    @(negedge clk);
    dAddress   = addr;
    dWriteData = data;
    MemRead    = rd;
    MemWrite   = wr;
    if (rd) sb.push_back('{name, exp});
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    op(1'b0, 1'b1, addr, data, "", 32'h0);
  endtask

  task automatic load(input logic [31:0] addr, input string name, input logic [31:0] exp);
    op(1'b1, 1'b0, addr, 32'h0, name, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: data is presented the cycle after a sampled load
  always @(posedge clk) begin
    if (rst_n && MemRead) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got 0x%08h expected no response", dReadData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, dReadData, e.exp);
      end
    end
  end

  // Start bit, 0x55 LSB first, stop bit
  logic [9:0] frame_bits = 10'b1010101010;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_seg", seg_value, 32'h0);
    check("rst_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_rdata", dReadData, 32'h0);
    load(A_TIMER, "rst_timer", 32'h0);

    store(32'h1001_0004, 32'hDEAD_BEEF);
    load(32'h1001_0004, "ram_w1", 32'hDEAD_BEEF);
    store(32'h1001_0000, 32'h1111_1111);
    load(32'h1001_0004, "ram_w1_kept", 32'hDEAD_BEEF);
    load(32'h1001_0000, "ram_w0", 32'h1111_1111);
    load(32'h1001_1000, "ram_past_end", 32'h0);
    store(32'h1001_1000, 32'h0000_0099);
    load(32'h1001_0000, "unmapped_store", 32'h1111_1111);
    load(32'h0000_0000, "unmapped_load", 32'h0);
    op(1'b1, 1'b1, 32'h1001_0004, 32'hCAFE_F00D, "read_first", 32'hDEAD_BEEF);
    load(32'h1001_0004, "after_rw", 32'hCAFE_F00D);
    idle(3);
    check("rdata_hold", dReadData, 32'hCAFE_F00D);

    store(A_LED, 32'h0001_A5A5);
    check("led_out", {16'b0, led}, 32'h0000_A5A5);
    load(A_LED, "led_read", 32'h0000_A5A5);
    store(A_SEG, 32'h1234_5678);
    check("seg_out", seg_value, 32'h1234_5678);
    load(A_SEG, "seg_read", 32'h1234_5678);
    load(32'hFFFF_0014, "io_hole", 32'h0);

    sw = 16'h00F0;
    idle(3);
    load(A_SW, "sw_read", 32'h0000_00F0);

    store(A_TIMER, 32'h0000_1234);
    idle(34);
    load(A_TIMER, "timer_35", 32'h3);
    store(A_TIMER, 32'h0);
    load(A_TIMER, "timer_clear", 32'h0);

    store(A_TIMER, 32'h0);
    force dut.timer_count = 32'hFFFF_FFFF;
    idle(1);
    release dut.timer_count;
    load(A_TIMER, "timer_max", 32'hFFFF_FFFF);
    idle(9);
    load(A_TIMER, "timer_wrap", 32'h0);

    store(A_UART, 32'h0000_0055);
    for (int k = 0; k < 10 * CPB; k++) begin
      check($sformatf("uart_bit_c%0d", k), {31'b0, uart_tx}, {31'b0, frame_bits[k / CPB]});
      if (k == 10)      store(A_UART, 32'h0000_00FF);
      else if (k == 20) load(A_UART, "uart_busy", 32'h1);
      else              idle(1);
    end
    check("uart_idle_tx", {31'b0, uart_tx}, 32'h1);
    load(A_UART, "uart_done", 32'h0);

    store(A_UART, 32'h0000_00AA);
    idle(5);
    check("uart_mid_bit0", {31'b0, uart_tx}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_mid_led", {16'b0, led}, 32'h0);
    check("rst_mid_seg", seg_value, 32'h0);
    check("rst_mid_rdata", dReadData, 32'h0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    load(A_UART, "rst_mid_status", 32'h0);

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
